// File: rtl/i2c_target_pkg.sv
// Shared types and helpers for the I2C target register bank.
package i2c_target_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    ADDR_ACK,
    WR_BYTE,
    WR_ACK,
    RD_BYTE,
    RD_ACK,
    IGNORE
  } i2c_tgt_state_e;

  localparam logic ACK  = 1'b0;
  localparam logic NACK = 1'b1;

  // Address byte carries the 7-bit address in [7:1] and R/W in [0].
  function automatic logic addr_match(input logic [7:0] addr_byte, input logic [6:0] addr);
    return addr_byte[7:1] == addr;
  endfunction

endpackage

// File: rtl/i2c_bus_sync.sv
// Synchronizes the asynchronous SCL/SDA pads and decodes bus edges and START/STOP.
module i2c_bus_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic scl_pad_i,
  input  logic sda_pad_i,
  output logic scl_rise,
  output logic scl_fall,
  output logic start_det,
  output logic stop_det,
  output logic sda_s
);

  logic [SYNC_STAGES-1:0] scl_sync;
  logic [SYNC_STAGES-1:0] sda_sync;
  logic                   scl_s;
  logic                   scl_d;
  logic                   sda_d;

  // Reset to the idle-bus level so leaving reset never looks like an edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scl_sync <= '1;
      sda_sync <= '1;
      scl_d    <= 1'b1;
      sda_d    <= 1'b1;
    end else begin
      scl_sync <= {scl_sync[SYNC_STAGES-2:0], scl_pad_i};
      sda_sync <= {sda_sync[SYNC_STAGES-2:0], sda_pad_i};
      scl_d    <= scl_s;
      sda_d    <= sda_s;
    end
  end

  assign scl_s     = scl_sync[SYNC_STAGES-1];
  assign sda_s     = sda_sync[SYNC_STAGES-1];
  assign scl_rise  = scl_s & ~scl_d;
  assign scl_fall  = ~scl_s & scl_d;
  assign start_det = scl_s & scl_d & sda_d & ~sda_s;
  assign stop_det  = scl_s & scl_d & ~sda_d & sda_s;

endmodule

// File: rtl/i2c_target_regs.sv
// I2C target exposing NUM_REGS byte registers with an auto-incrementing pointer.
module i2c_target_regs
  import i2c_target_pkg::*;
#(
  parameter logic [6:0] TARGET_ADDR = 7'h42,
  parameter int         NUM_REGS    = 16,
  parameter int         SYNC_STAGES = 2,
  localparam int        IW          = $clog2(NUM_REGS)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  scl_pad_i,
  input  logic                  sda_pad_i,
  output logic                  sda_pad_o,
  output logic                  sda_padoen_o,
  output logic [NUM_REGS*8-1:0] regs_o,
  output logic                  wr_valid_o,
  output logic [IW-1:0]         wr_idx_o,
  output logic                  busy_o
);

  logic scl_rise, scl_fall, start_det, stop_det, sda_s;

  i2c_bus_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk       (clk),
    .rst_n     (rst_n),
    .scl_pad_i (scl_pad_i),
    .sda_pad_i (sda_pad_i),
    .scl_rise  (scl_rise),
    .scl_fall  (scl_fall),
    .start_det (start_det),
    .stop_det  (stop_det),
    .sda_s     (sda_s)
  );

  i2c_tgt_state_e state_q, state_d;
  logic [3:0]     bit_cnt_q, bit_cnt_d;
  logic [7:0]     shift_q, shift_d;
  logic [IW-1:0]  ptr_q, ptr_d;
  logic           oen_q, oen_d;
  logic           first_q, first_d;
  logic           ack_q, ack_d;
  logic           wr_en;
  logic [7:0]     regs [NUM_REGS];
  logic [7:0]     rd_byte;

  assign rd_byte = regs[ptr_q];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      ptr_q     <= '0;
      oen_q     <= 1'b0;
      first_q   <= 1'b0;
      ack_q     <= NACK;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      ptr_q     <= ptr_d;
      oen_q     <= oen_d;
      first_q   <= first_d;
      ack_q     <= ack_d;
    end
  end

  // Bus conditions override any bit-level activity; everything else advances on SCL edges.
  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    ptr_d     = ptr_q;
    oen_d     = oen_q;
    first_d   = first_q;
    ack_d     = ack_q;
    wr_en     = 1'b0;
    if (start_det) begin
      state_d   = ADDR;
      bit_cnt_d = '0;
      oen_d     = 1'b0;
    end else if (stop_det) begin
      state_d   = IDLE;
      bit_cnt_d = '0;
      oen_d     = 1'b0;
    end else begin
      case (state_q)
        ADDR, WR_BYTE: begin
          if (scl_rise) begin
            shift_d   = {shift_q[6:0], sda_s};
            bit_cnt_d = bit_cnt_q + 4'd1;
          end else if (scl_fall && bit_cnt_q == 4'd8) begin
            bit_cnt_d = '0;
            if (state_q == ADDR) begin
              if (addr_match(shift_q, TARGET_ADDR)) begin
                state_d = ADDR_ACK;
                oen_d   = 1'b1;
              end else begin
                state_d = IGNORE;
              end
            end else begin
              state_d = WR_ACK;
              oen_d   = 1'b1;
              if (first_q) begin
                ptr_d   = shift_q[IW-1:0];
                first_d = 1'b0;
              end else begin
                wr_en = 1'b1;
                ptr_d = ptr_q + 1'b1;
              end
            end
          end
        end
        ADDR_ACK: begin
          if (scl_fall) begin
            bit_cnt_d = '0;
            if (shift_q[0] == 1'b0) begin
              state_d = WR_BYTE;
              first_d = 1'b1;
              oen_d   = 1'b0;
            end else begin
              state_d = RD_BYTE;
              shift_d = rd_byte;
              oen_d   = ~rd_byte[7];
            end
          end
        end
        WR_ACK: begin
          if (scl_fall) begin
            state_d   = WR_BYTE;
            bit_cnt_d = '0;
            oen_d     = 1'b0;
          end
        end
        RD_BYTE: begin
          if (scl_rise) begin
            bit_cnt_d = bit_cnt_q + 4'd1;
          end else if (scl_fall) begin
            if (bit_cnt_q == 4'd8) begin
              state_d   = RD_ACK;
              bit_cnt_d = '0;
              oen_d     = 1'b0;
              ptr_d     = ptr_q + 1'b1;
            end else begin
              shift_d = {shift_q[6:0], 1'b0};
              oen_d   = ~shift_q[6];
            end
          end
        end
        RD_ACK: begin
          if (scl_rise) begin
            ack_d = sda_s;
          end else if (scl_fall) begin
            if (ack_q == ACK) begin
              state_d = RD_BYTE;
              shift_d = rd_byte;
              oen_d   = ~rd_byte[7];
            end else begin
              state_d = IGNORE;
            end
          end
        end
        IDLE, IGNORE: ;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
      wr_valid_o <= 1'b0;
      wr_idx_o   <= '0;
    end else begin
      wr_valid_o <= wr_en;
      if (wr_en) begin
        regs[ptr_q] <= shift_q;
        wr_idx_o    <= ptr_q;
      end
    end
  end

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_flat
    assign regs_o[8*g +: 8] = regs[g];
  end

  assign sda_pad_o    = 1'b0;
  assign sda_padoen_o = oen_q;
  assign busy_o       = (state_q != IDLE);

endmodule

// File: tb/tb_i2c_target_regs.sv
// Bit-banged I2C master driving i2c_target_regs, checked against a byte-level register model.
module tb_i2c_target_regs;

  localparam int NUM = 16;
  localparam int Q   = 5;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           scl_m = 1'b1;
  logic           sda_m = 1'b1;
  logic           sda_bus;
  logic           sda_pad_o, sda_padoen_o, wr_valid_o, busy_o;
  logic [NUM*8-1:0] regs_o;
  logic [3:0]     wr_idx_o;

  assign sda_bus = sda_m & ~sda_padoen_o;

  i2c_target_regs #(.TARGET_ADDR(7'h42), .NUM_REGS(NUM), .SYNC_STAGES(2)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .scl_pad_i    (scl_m),
    .sda_pad_i    (sda_bus),
    .sda_pad_o    (sda_pad_o),
    .sda_padoen_o (sda_padoen_o),
    .regs_o       (regs_o),
    .wr_valid_o   (wr_valid_o),
    .wr_idx_o     (wr_idx_o),
    .busy_o       (busy_o)
  );

  always #5 clk = ~clk;

  int         n_asserts = 0;
  int         n_fail = 0;
  logic [7:0] model_regs [NUM];
  int         model_ptr = 0;
  logic [3:0] wr_log[$];
  logic [3:0] exp_wr[$];
  logic [7:0] tx_q[$];
  bit         oen_seen = 1'b0;

  always @(negedge clk) begin
    if (wr_valid_o) wr_log.push_back(wr_idx_o);
    if (sda_padoen_o) oen_seen = 1'b1;
  end

  initial begin
    #2ms;
    $display("[TB] FAIL watchdog: simulation time limit expired");
    $fatal(1, "[TB] timeout");
  end

  task automatic checkOutput(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [127:0] model_flat();
    logic [127:0] r;
    for (int i = 0; i < NUM; i++) r[8*i +: 8] = model_regs[i];
    return r;
  endfunction

  // First byte of a write sets the pointer; each later byte lands at the pointer which then advances.
  function automatic void model_write();
    if (tx_q.size() > 0) model_ptr = tx_q[0] % NUM;
    for (int i = 1; i < tx_q.size(); i++) begin
      model_regs[model_ptr] = tx_q[i];
      exp_wr.push_back(4'(model_ptr));
      model_ptr = (model_ptr + 1) % NUM;
    end
  endfunction

  task automatic wait_q(input int n = 1);
    repeat (n * Q) @(negedge clk);
  endtask

  task automatic write_bit(input logic v);
    sda_m = v; wait_q(); scl_m = 1'b1; wait_q(2); scl_m = 1'b0; wait_q();
  endtask

  task automatic read_bit(output logic v);
    sda_m = 1'b1; wait_q(); scl_m = 1'b1; wait_q(); v = sda_bus; wait_q(); scl_m = 1'b0; wait_q();
  endtask

  task automatic i2c_start();
    sda_m = 1'b1; wait_q(); scl_m = 1'b1; wait_q(); sda_m = 1'b0; wait_q(); scl_m = 1'b0; wait_q();
  endtask

  task automatic i2c_stop();
    sda_m = 1'b0; wait_q(); scl_m = 1'b1; wait_q(); sda_m = 1'b1; wait_q(2);
  endtask

  task automatic send_byte(input logic [7:0] b, output logic ack);
    for (int i = 7; i >= 0; i--) write_bit(b[i]);
    read_bit(ack);
  endtask

  task automatic recv_byte(input logic ack_bit, output logic [7:0] b);
    logic v;
    for (int i = 7; i >= 0; i--) begin
      read_bit(v);
      b[i] = v;
    end
    write_bit(ack_bit);
  endtask

  task automatic check_log(input string tag);
    checkOutput({tag, " wr count"}, 128'(wr_log.size()), 128'(exp_wr.size()));
    for (int i = 0; i < wr_log.size() && i < exp_wr.size(); i++)
      checkOutput({tag, " wr idx"}, 128'(wr_log[i]), 128'(exp_wr[i]));
    wr_log.delete();
    exp_wr.delete();
  endtask

  // Full write transaction to our address using the bytes queued in tx_q.
  task automatic applyStimulus(input string tag);
    logic ack;
    i2c_start();
    checkOutput({tag, " busy"}, 128'(busy_o), 128'(1));
    send_byte(8'h84, ack);
    checkOutput({tag, " addr ack"}, 128'(ack), 128'(0));
    foreach (tx_q[i]) begin
      send_byte(tx_q[i], ack);
      checkOutput({tag, " data ack"}, 128'(ack), 128'(0));
    end
    i2c_stop();
    checkOutput({tag, " idle"}, 128'(busy_o), 128'(0));
    model_write();
    tx_q.delete();
    check_log(tag);
    checkOutput({tag, " regs"}, regs_o, model_flat());
  endtask

  // Read n bytes from the current pointer (START or repeated START), NACKing the last.
  task automatic read_seq(input int n, input string tag);
    logic ack;
    logic [7:0] d;
    i2c_start();
    send_byte(8'h85, ack);
    checkOutput({tag, " rd addr ack"}, 128'(ack), 128'(0));
    for (int i = 0; i < n; i++) begin
      recv_byte((i == n - 1) ? 1'b1 : 1'b0, d);
      checkOutput({tag, " rd data"}, 128'(d), 128'(model_regs[model_ptr]));
      model_ptr = (model_ptr + 1) % NUM;
    end
    wait_q();
    checkOutput({tag, " released"}, 128'(sda_padoen_o), 128'(0));
    i2c_stop();
  endtask

  initial begin
    logic ack;
    logic [7:0] p;
    foreach (model_regs[i]) model_regs[i] = 8'h00;

    repeat (5) @(negedge clk);
    checkOutput("reset regs", regs_o, 128'(0));
    checkOutput("reset busy", 128'(busy_o), 128'(0));
    checkOutput("reset oen", 128'(sda_padoen_o), 128'(0));
    checkOutput("reset wr_valid", 128'(wr_valid_o), 128'(0));
    checkOutput("sda_pad_o", 128'(sda_pad_o), 128'(0));
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    $display("[TB] test 1: pointer write and two data bytes");
    tx_q = '{8'h03, 8'hA5, 8'h5A};
    applyStimulus("t1");
    checkOutput("t1 reg3", 128'(regs_o[31:24]), 128'(8'hA5));
    checkOutput("t1 reg4", 128'(regs_o[39:32]), 128'(8'h5A));

    $display("[TB] test 2: pointer set, repeated START, read");
    i2c_start();
    send_byte(8'h84, ack);
    checkOutput("t2 addr ack", 128'(ack), 128'(0));
    send_byte(8'h03, ack);
    checkOutput("t2 ptr ack", 128'(ack), 128'(0));
    model_ptr = 3;
    read_seq(2, "t2");
    check_log("t2");

    $display("[TB] test 3: foreign address");
    oen_seen = 1'b0;
    i2c_start();
    send_byte(8'h86, ack);
    checkOutput("t3 addr nack", 128'(ack), 128'(1));
    send_byte(8'h11, ack);
    checkOutput("t3 data nack", 128'(ack), 128'(1));
    checkOutput("t3 busy", 128'(busy_o), 128'(1));
    i2c_stop();
    checkOutput("t3 idle", 128'(busy_o), 128'(0));
    checkOutput("t3 never driven", 128'(oen_seen), 128'(0));
    checkOutput("t3 regs", regs_o, model_flat());
    check_log("t3");

    $display("[TB] test 4: pointer wrap");
    tx_q = '{8'h0F, 8'h11, 8'h22};
    applyStimulus("t4a");
    checkOutput("t4 reg15", 128'(regs_o[127:120]), 128'(8'h11));
    checkOutput("t4 reg0", 128'(regs_o[7:0]), 128'(8'h22));
    tx_q = '{8'h1F, 8'h33};
    applyStimulus("t4b");
    checkOutput("t4 reg15 via 1F", 128'(regs_o[127:120]), 128'(8'h33));

    $display("[TB] test 5: STOP inside a data byte");
    i2c_start();
    send_byte(8'h84, ack);
    send_byte(8'h07, ack);
    model_ptr = 7;
    for (int i = 0; i < 5; i++) write_bit(1'($urandom));
    i2c_stop();
    checkOutput("t5 idle", 128'(busy_o), 128'(0));
    checkOutput("t5 regs", regs_o, model_flat());
    check_log("t5");
    read_seq(1, "t5 rd");
    tx_q = '{8'h07, 8'hC3};
    applyStimulus("t5 wr");

    $display("[TB] random transactions");
    for (int it = 0; it < 10; it++) begin
      tx_q.push_back(8'($urandom));
      for (int k = 0; k < int'($urandom_range(1, 4)); k++) tx_q.push_back(8'($urandom));
      applyStimulus("rnd wr");
      p = 8'($urandom);
      i2c_start();
      send_byte(8'h84, ack);
      checkOutput("rnd ptr addr ack", 128'(ack), 128'(0));
      send_byte(p, ack);
      model_ptr = p % NUM;
      read_seq(int'($urandom_range(1, 4)), "rnd");
      check_log("rnd rd");
    end

    $display("[TB] test 6: reset while driving a read bit");
    tx_q = '{8'h04, 8'h5A};
    applyStimulus("t6 wr");
    i2c_start();
    send_byte(8'h84, ack);
    send_byte(8'h04, ack);
    i2c_start();
    send_byte(8'h85, ack);
    checkOutput("t6 rd addr ack", 128'(ack), 128'(0));
    wait_q();
    checkOutput("t6 driving low", 128'(sda_padoen_o), 128'(1));
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1 checkOutput("t6 async release", 128'(sda_padoen_o), 128'(0));
    sda_m = 1'b1;
    scl_m = 1'b1;
    repeat (5) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    foreach (model_regs[i]) model_regs[i] = 8'h00;
    model_ptr = 0;
    wr_log.delete();
    checkOutput("t6 regs cleared", regs_o, 128'(0));
    checkOutput("t6 busy", 128'(busy_o), 128'(0));
    checkOutput("t6 wr_valid", 128'(wr_valid_o), 128'(0));
    tx_q = '{8'h01, 8'h77};
    applyStimulus("t6 after");

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
